// File: rtl/ysyx_23060191_imem_pkg.sv
// Shared definitions for the instruction memory: CPU width, reset PC,
// FSM state encodings and the address-fault helper.
package ysyx_23060191_imem_pkg;

  localparam int          CPU_WIDTH = 32;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam int          CNT_WIDTH = 4;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } imem_state_e;

  // Misaligned PC or word index past the end of the image is a fetch fault.
  function automatic logic fetch_fault(input logic [CPU_WIDTH-1:0] addr,
                                       input logic [CPU_WIDTH-1:0] word_idx,
                                       input int unsigned depth);
    return (addr[1:0] != 2'b00) || (word_idx >= CPU_WIDTH'(depth));
  endfunction

endpackage

// File: rtl/ysyx_23060191_imem_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every cycle; supplies
// the extra fetch delay when IMEM_RANDOM_DELAY_EN is defined.
module ysyx_23060191_LFSR
  import ysyx_23060191_imem_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

endmodule

// File: rtl/ysyx_23060191_imem_reg.sv
// Generic enable register with asynchronous active-low reset, used for
// the instruction memory's state and delay counter.
module ysyx_23060191_RegTemplate #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_23060191_imem.sv
// Instruction memory with a valid/ready fetch port and fixed LATENCY; one
// request in flight. Define IMEM_RANDOM_DELAY_EN to add 0..3 LFSR-driven cycles.
module ysyx_23060191_imem
  import ysyx_23060191_imem_pkg::*;
#(
  parameter int unsigned          DEPTH_WORDS = 1024,
  parameter logic [CPU_WIDTH-1:0] BASE_ADDR   = RESET_PC,
  parameter int unsigned          LATENCY     = 2,
  parameter string                INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CPU_WIDTH-1:0] req_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CPU_WIDTH-1:0] rsp_inst,
  output logic                 rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [CPU_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [1:0]           state_q;
  imem_state_e          state;
  imem_state_e          state_next;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] extra_delay;
  logic                 load_rsp;

  logic [CPU_WIDTH-1:0] addr_q;
  logic [CPU_WIDTH-1:0] offset;
  logic [CPU_WIDTH-1:0] word_idx;
  logic                 fault;

  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic [CPU_WIDTH-1:0] rsp_inst_q;
  logic                 rsp_err_q;

  ysyx_23060191_RegTemplate #(.WIDTH(2), .RESET_VAL(2'(ST_IDLE))) u_state_reg (
    .clk  (clk),
    .rstn (rstn),
    .wen  (1'b1),
    .din  (state_next),
    .dout (state_q)
  );

  ysyx_23060191_RegTemplate #(.WIDTH(CNT_WIDTH), .RESET_VAL('0)) u_cnt_reg (
    .clk  (clk),
    .rstn (rstn),
    .wen  (1'b1),
    .din  (cnt_next),
    .dout (cnt_q)
  );

  assign state = imem_state_e'(state_q);

`ifdef IMEM_RANDOM_DELAY_EN
  logic [7:0] lfsr_q;

  ysyx_23060191_LFSR u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .lfsr (lfsr_q)
  );

  assign extra_delay = {{(CNT_WIDTH-2){1'b0}}, lfsr_q[1:0]};
`else
  assign extra_delay = '0;
`endif

  // The counter holds the WAIT cycles still to go before the array read.
  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    load_rsp   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_next = ST_WAIT;
          cnt_next   = CNT_WIDTH'(LATENCY - 1) + extra_delay;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_next = ST_RESP;
          load_rsp   = 1'b1;
        end else begin
          cnt_next = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Wrapping subtraction sends addresses below BASE_ADDR far out of range.
  assign offset   = addr_q - BASE_ADDR;
  assign word_idx = offset >> 2;
  assign fault    = fetch_fault(addr_q, word_idx, DEPTH_WORDS);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        addr_q <= req_addr;
      end
      req_ready_q <= (state_next == ST_IDLE);
      rsp_valid_q <= (state_next == ST_RESP);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_inst_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (load_rsp) begin
      rsp_inst_q <= fault ? '0 : mem[word_idx[IDX_W-1:0]];
      rsp_err_q  <= fault;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_inst  = rsp_inst_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_23060191_imem.sv
// Bench for ysyx_23060191_imem: directed fetches against a transaction-level
// model, plus a LATENCY=1 instance for back-to-back throughput.
module tb_ysyx_23060191_imem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT   = 2;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr  = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_inst;
  logic        rsp_err;

  logic        req_valid1 = 1'b0;
  logic        req_ready1;
  logic [31:0] req_addr1  = '0;
  logic        rsp_valid1;
  logic        rsp_ready1 = 1'b0;
  logic [31:0] rsp_inst1;
  logic        rsp_err1;

  always #5 clk = ~clk;

  ysyx_23060191_imem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err)
  );

  ysyx_23060191_imem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1), .INIT_FILE("")) dut1 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_inst(rsp_inst1), .rsp_err(rsp_err1)
  );

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] img [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected fetch result straight from the byte-address rules.
  task automatic ref_fetch(input logic [31:0] a, output logic [31:0] inst, output logic err);
    logic [31:0] off;
    off = a - BASE;
    if (a[1:0] != 2'b00 || off >= 32'(DEPTH * 4)) begin
      inst = '0;
      err  = 1'b1;
    end else begin
      inst = img[off[11:2]];
      err  = 1'b0;
    end
  endtask

  // Transaction model of the main instance: cycles left until the response
  // appears, and the response that is (or was last) presented.
  bit          m_busy = 1'b0;
  bit          m_resp = 1'b0;
  int          m_left = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_inst = '0;
  logic        m_err  = 1'b0;
  logic [7:0]  m_lfsr = 8'hA5;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_busy = 1'b0;
        m_resp = 1'b0;
        m_left = 0;
        m_inst = '0;
        m_err  = 1'b0;
        m_lfsr = 8'hA5;
      end else begin
        if (m_resp) begin
          if (rsp_ready) m_resp = 1'b0;
        end else if (m_busy) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_resp = 1'b1;
            ref_fetch(m_addr, m_inst, m_err);
          end
        end else if (req_valid) begin
          m_busy = 1'b1;
          m_addr = req_addr;
          m_left = LAT;
`ifdef IMEM_RANDOM_DELAY_EN
          m_left = m_left + int'(m_lfsr[1:0]);
`endif
        end
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      end
    end
  end

  initial begin
    @(negedge rstn);
    forever begin
      @(negedge clk);
      chk("cmp_req_ready", 32'(req_ready), 32'(!(m_busy || m_resp)));
      chk("cmp_rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("cmp_rsp_inst",  rsp_inst, m_inst);
      chk("cmp_rsp_err",   32'(rsp_err), 32'(m_err));
    end
  end

  task automatic fetch(input logic [31:0] a, input int hold,
                       input logic [31:0] exp_inst, input logic exp_err);
    int n;
    int lat;
    req_addr  = a;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    chk("accept_timeout", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    req_addr  = ~a;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
`ifdef IMEM_RANDOM_DELAY_EN
    chk("latency_range", 32'(lat >= LAT && lat <= LAT + 3), 32'd1);
`else
    chk("latency", 32'(lat), 32'(LAT));
`endif
    chk("rsp_inst", rsp_inst, exp_inst);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #2;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_inst", rsp_inst, exp_inst);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    chk("idle_after_resp", 32'(req_ready), 32'd1);
    $display("fetch addr=%h lat=%0d hold=%0d inst=%h err=%0b", a, lat, hold, rsp_inst, rsp_err);
  endtask

  logic [31:0] v_addr [8];
  logic [31:0] v_inst [8];
  logic        v_err  [8];
  int          v_hold [8];

  initial begin
    int          resp_cnt;
    int          last_c;
    logic        acc;

    for (int i = 0; i < DEPTH; i++) img[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    img[0]    = 32'h0000_0297;
    img[1]    = 32'h00A0_0513;
    img[2]    = 32'h0010_0073;
    img[1023] = 32'hCAFE_F00D;
    for (int i = 0; i < DEPTH; i++) begin
      dut.mem[i]  = img[i];
      dut1.mem[i] = img[i];
    end

    v_addr[0] = 32'h8000_0000; v_inst[0] = 32'h0000_0297; v_err[0] = 1'b0; v_hold[0] = 0;
    v_addr[1] = 32'h8000_0004; v_inst[1] = 32'h00A0_0513; v_err[1] = 1'b0; v_hold[1] = 1;
    v_addr[2] = 32'h8000_0008; v_inst[2] = 32'h0010_0073; v_err[2] = 1'b0; v_hold[2] = 0;
    v_addr[3] = 32'h8000_0FFC; v_inst[3] = 32'hCAFE_F00D; v_err[3] = 1'b0; v_hold[3] = 2;
    v_addr[4] = 32'h8000_0002; v_inst[4] = 32'h0000_0000; v_err[4] = 1'b1; v_hold[4] = 0;
    v_addr[5] = 32'h8000_1000; v_inst[5] = 32'h0000_0000; v_err[5] = 1'b1; v_hold[5] = 0;
    v_addr[6] = 32'h7FFF_FFFC; v_inst[6] = 32'h0000_0000; v_err[6] = 1'b1; v_hold[6] = 0;
    v_addr[7] = 32'h8000_0001; v_inst[7] = 32'h0000_0000; v_err[7] = 1'b1; v_hold[7] = 1;

    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_inst", rsp_inst, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #2;

    for (int i = 0; i < 8; i++) fetch(v_addr[i], v_hold[i], v_inst[i], v_err[i]);

    // Consumer stalls for five cycles.
    fetch(32'h8000_0004, 5, 32'h00A0_0513, 1'b0);

    // Reset pulse while the request is in WAIT drops it.
    req_addr  = 32'h8000_0008;
    req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wait_req_ready", 32'(req_ready), 32'd0);
    rstn = 1'b0;
    #1;
    chk("async_rst_req_ready", 32'(req_ready), 32'd1);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      chk("dropped_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    $display("reset during WAIT: request dropped");
    fetch(32'h8000_0000, 0, 32'h0000_0297, 1'b0);

    // Back-to-back on the LATENCY=1 instance.
    resp_cnt   = 0;
    last_c     = -1;
    req_addr1  = BASE;
    req_valid1 = 1'b1;
    rsp_ready1 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      acc = req_ready1;
      @(posedge clk); #2;
      if (acc) req_addr1 = req_addr1 + 32'd4;
      if (rsp_valid1) begin
        chk("b2b_inst", rsp_inst1, img[resp_cnt]);
        chk("b2b_err", 32'(rsp_err1), 32'd0);
`ifndef IMEM_RANDOM_DELAY_EN
        if (last_c >= 0) chk("b2b_spacing", 32'(c - last_c), 32'd3);
`endif
        $display("b2b rsp #%0d cycle=%0d inst=%h", resp_cnt, c, rsp_inst1);
        last_c = c;
        resp_cnt++;
      end
    end
    req_valid1 = 1'b0;
`ifndef IMEM_RANDOM_DELAY_EN
    chk("b2b_count", 32'(resp_cnt), 32'd5);
`else
    chk("b2b_some", 32'(resp_cnt > 0), 32'd1);
`endif
    repeat (12) @(posedge clk);
    #2;

`ifdef IMEM_RANDOM_DELAY_EN
    for (int k = 0; k < 100; k++) fetch(v_addr[k % 4], 0, v_inst[k % 4], 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060191_imem.md
YSYX_23060191_IMEM -- requirements
Module: ysyx_23060191_IMEM

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning instruction words stored (4 KiB).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h80000000, meaning byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, legal 1..7, meaning cycles from request accept to response valid.
REQ-004 SHALL have parameter INIT_FILE, default "", meaning hex image loaded at elaboration when non-empty.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  in  1  fetch request from PC side.
REQ-008 SHALL have port req_ready  out  1  request accepted when both high at a rising edge.
REQ-009 SHALL have port req_addr  in  CPU_WIDTH  fetch byte address (the PC).
REQ-010 SHALL have port rsp_valid  out  1  response available.
REQ-011 SHALL have port rsp_ready  in  1  consumer takes response when both high.
REQ-012 SHALL have port rsp_inst  out  CPU_WIDTH  fetched instruction word.
REQ-013 SHALL have port rsp_err  out  1  fetch fault flag for this response.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, one outstanding request.
REQ-015 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-016 SHALL on accept in IDLE capture req_addr, load delay counter with LATENCY-1, go WAIT.
REQ-017 SHALL in WAIT decrement counter each cycle; at zero read array, register rsp_inst/rsp_err, go RESP.
REQ-018 SHALL make rsp_valid rise exactly LATENCY cycles after the accepting edge (no random delay).
REQ-019 SHALL hold rsp_inst, rsp_err, rsp_valid stable in RESP until rsp_ready=1; then go IDLE next edge.
REQ-020 SHALL insert one idle cycle between responses (req_ready only after RESP exits); max throughput 1 per LATENCY+2 cycles.
REQ-021 SHALL compute index = (addr - BASE_ADDR) >> 2, using CPU_WIDTH-bit unsigned subtraction (wrap allowed).
REQ-022 SHALL flag rsp_err=1 and rsp_inst=32'h00000000 when addr[1:0]!=0 or index >= DEPTH_WORDS.
REQ-023 SHALL ignore req_addr changes and req_valid while in WAIT or RESP.
REQ-024 SHALL keep rsp_inst/rsp_err at last values outside RESP (no output toggling).

Reset
REQ-025 SHALL on rstn=0 asynchronously force state=IDLE, req_ready=1 after release, rsp_valid=0, rsp_inst=0, rsp_err=0, counter=0.
REQ-026 SHALL drop any in-flight request on reset mid-WAIT or mid-RESP; no response after release.
REQ-027 SHALL not reset the memory array contents.

Configuration
REQ-028 SHALL with macro IMEM_RANDOM_DELAY_EN defined add 0..3 extra WAIT cycles equal to lfsr[1:0] sampled at accept.
REQ-029 SHALL use 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5 on reset, advancing every cycle.
REQ-030 SHALL without IMEM_RANDOM_DELAY_EN contain no LFSR and have fixed latency per REQ-018.

Structure
REQ-031 SHALL take CPU_WIDTH, reset PC 32'h80000000 and FSM state encodings from the shared defines file.
REQ-032 SHALL place the LFSR in sub-module ysyx_23060191_LFSR, instantiated only under IMEM_RANDOM_DELAY_EN.
REQ-033 SHALL build state/counter registers with the team's RegTemplate register.

Verification
REQ-034 SHALL cover: image word0=32'h00000297, req 0x80000000 accepted at T -> rsp_valid at T+2, rsp_inst=32'h00000297, rsp_err=0.
REQ-035 SHALL cover: req 0x80000002 -> rsp_err=1, rsp_inst=0; req 0x80001000 (DEPTH 1024) -> rsp_err=1.
REQ-036 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_inst stable, req_ready=0 throughout.
REQ-037 SHALL cover: rstn pulsed low during WAIT -> rsp_valid=0, no response for that request, next req served normally.
REQ-038 SHALL cover: back-to-back req_valid=1, rsp_ready=1, LATENCY=1 -> one response every 3 cycles, in order.
REQ-039 SHALL cover with IMEM_RANDOM_DELAY_EN: 100 fetches -> each latency in 2..5, data correct, seed reproducible.
